// File: rtl/lfsr_decrypt_engine_if.sv
// Host/data-memory side of the LFSR decrypt engine: start/status handshake plus
// an asynchronous-read, clocked-write byte memory port.
interface lfsr_decrypt_engine_if;
  logic       start;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       done;
  logic       error;
  logic [7:0] found_ptrn;
  logic [7:0] found_init;
  logic [5:0] msg_len;

  // Host and memory side: issues start, returns read data, observes results.
  modport master (
    output start, mem_rd_data,
    input  mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  done, error, found_ptrn, found_init, msg_len
  );

  // Engine side.
  modport slave (
    input  start, mem_rd_data,
    output mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output done, error, found_ptrn, found_init, msg_len
  );
endinterface

// File: rtl/lfsr_decrypt_engine.sv
// Recovers the LFSR tap pattern and seed of an encrypted frame from its space-padded
// preamble, then writes the decrypted message (leading spaces stripped) back to memory.
module lfsr_decrypt_engine #(
  parameter logic [7:0] MSG_BASE  = 8'd64,
  parameter logic [7:0] OUT_BASE  = 8'd0,
  parameter int         FRAME_LEN = 64,
  parameter int         MAX_OUT   = 41,
  parameter logic [7:0] PAD_CHAR  = 8'h20
) (
  input logic                 clk,
  input logic                 reset,
  lfsr_decrypt_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, SELECT, DECRYPT, DONE, FAIL} state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic [7:0] p);
    return {l[6:0], ^(l & p)};
  endfunction

  function automatic logic [7:0] pattern(input logic [2:0] k);
    case (k)
      3'd0:    pattern = 8'hE1;
      3'd1:    pattern = 8'hD4;
      3'd2:    pattern = 8'hC6;
      3'd3:    pattern = 8'hB8;
      3'd4:    pattern = 8'hB4;
      3'd5:    pattern = 8'hB2;
      3'd6:    pattern = 8'hFA;
      default: pattern = 8'hF3;
    endcase
  endfunction

  // Lowest set index wins when several candidate lanes explain the preamble.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (m[k]) lowest_set = 3'(k);
  endfunction

  state_t     state;
  logic [7:0] lane      [8];
  logic [7:0] lane_next [8];
  logic [7:0] hit;
  logic [7:0] mask;
  logic [7:0] l0;
  logic [7:0] lfsr;
  logic [7:0] ptrn;
  logic [3:0] idx;
  logic [5:0] j;
  logic [5:0] wr_ptr;
  logic       skipping;

  logic [7:0] key_byte;
  logic [7:0] plain;
  logic       emit;
  logic       cap_hit;
  logic       last_byte;

  assign key_byte  = bus.mem_rd_data ^ PAD_CHAR;
  assign plain     = bus.mem_rd_data ^ lfsr;
  assign emit      = (state == DECRYPT) && !(skipping && (plain == PAD_CHAR));
  assign cap_hit   = emit && ((wr_ptr + 6'd1) == 6'(MAX_OUT));
  assign last_byte = (j == 6'(FRAME_LEN - 1));

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane_next[k] = lfsr_step(lane[k], pattern(3'(k)));
      hit[k]       = (lane_next[k] == key_byte);
    end
  end

  // The memory reads asynchronously, so the address and write strobe are decoded from
  // the current state to sustain one byte per cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bus.mem_rd_addr = 8'd0;
    case (state)
      LOAD:    bus.mem_rd_addr = MSG_BASE;
      SEARCH:  bus.mem_rd_addr = MSG_BASE + {4'd0, idx};
      DECRYPT: bus.mem_rd_addr = MSG_BASE + {2'd0, j};
      default: bus.mem_rd_addr = 8'd0;
    endcase
  end

  assign bus.mem_wr_en   = emit;
  assign bus.mem_wr_addr = emit ? (OUT_BASE + {2'd0, wr_ptr}) : 8'd0;
  assign bus.mem_wr_data = emit ? plain : 8'd0;

  // NOTE: candidate lanes carry no reset; LOAD overwrites all of them before any use.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int k = 0; k < 8; k++) lane[k] <= key_byte;
    end else if (state == SEARCH) begin
      for (int k = 0; k < 8; k++) lane[k] <= lane_next[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.found_ptrn <= 8'd0;
      bus.found_init <= 8'd0;
      bus.msg_len    <= 6'd0;
      mask           <= 8'd0;
      l0             <= 8'd0;
      lfsr           <= 8'd0;
      ptrn           <= 8'd0;
      idx            <= 4'd0;
      j              <= 6'd0;
      wr_ptr         <= 6'd0;
      skipping       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (bus.start) begin
            bus.done    <= 1'b0;
            bus.error   <= 1'b0;
            bus.msg_len <= 6'd0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          l0    <= key_byte;
          mask  <= 8'hFF;
          idx   <= 4'd1;
          state <= SEARCH;
        end
        SEARCH: begin
          mask <= mask & hit;
          if (idx == 4'd8) state <= SELECT;
          else             idx   <= idx + 4'd1;
        end
        SELECT: begin
          if (mask == 8'd0) begin
            bus.done    <= 1'b1;
            bus.error   <= 1'b1;
            bus.msg_len <= 6'd0;
            state       <= FAIL;
          end else begin
            ptrn           <= pattern(lowest_set(mask));
            bus.found_ptrn <= pattern(lowest_set(mask));
            bus.found_init <= l0;
            lfsr           <= l0;
            j              <= 6'd0;
            wr_ptr         <= 6'd0;
            skipping       <= 1'b1;
            state          <= DECRYPT;
          end
        end
        DECRYPT: begin
          lfsr <= lfsr_step(lfsr, ptrn);
          j    <= j + 6'd1;
          if (emit) begin
            wr_ptr   <= wr_ptr + 6'd1;
            skipping <= 1'b0;
          end
          if (cap_hit || last_byte) begin
            bus.done    <= 1'b1;
            bus.msg_len <= emit ? (wr_ptr + 6'd1) : wr_ptr;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
